// File: rtl/conv1d_ctrl_fsm.sv
// conv1d_ctrl_fsm
// Sequencer for the conv1d accelerator. It accepts a job from the control
// registers and loads K weights into the datapath weight buffer. It then
// computes N-K+1 valid-convolution outputs. Each output is a fresh accumulation
// of K input samples multiplied by the buffered weights. Every finished output
// is handed to the output stage over a valid/ready handshake.
//
// Ports
//   clk_i, rst_i             clock, asynchronous active-high reset
//   start_i, abort_i         job start pulse / abandon current job
//   in_base_i, wgt_base_i    word-aligned base addresses of input / weights
//   in_len_i, k_len_i        input length N and kernel length K (samples)
//   busy_o, done_o, err_o    status back to the control registers
//   mem_req_o, mem_addr_o    single-outstanding read request
//   mem_gnt_i, mem_rvalid_i  request accepted / read data returned
//   wgt_we_o, wgt_idx_o      weight buffer write strobe and index (also the
//                            weight index used by the MAC)
//   mac_clr_o, mac_en_o      accumulator clear / accumulate returned sample
//   out_valid_o, out_ready_i result handshake with the output stage
module conv1d_ctrl_fsm #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16,
  parameter int KMAX   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [ADDR_W-1:0]       in_base_i,
  input  logic [ADDR_W-1:0]       wgt_base_i,
  input  logic [LEN_W-1:0]        in_len_i,
  input  logic [LEN_W-1:0]        k_len_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic                    mem_req_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  output logic                    wgt_we_o,
  output logic [$clog2(KMAX)-1:0] wgt_idx_o,
  output logic                    mac_clr_o,
  output logic                    mac_en_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i
);

  localparam int                IDX_W      = $clog2(KMAX);
  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);
  localparam logic [LEN_W-1:0]  KMAX_LEN   = LEN_W'(KMAX);

  // S_DRAIN waits out a granted read after an abort so that the returning
  // data can never be mistaken for the reply to a later job's request.
  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_LOAD_W,
    S_CONV,
    S_OUT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_inBase;
  logic [ADDR_W-1:0] r_wgtBase;
  logic [LEN_W-1:0]  r_inLen;
  logic [LEN_W-1:0]  r_kLen;
  logic [LEN_W-1:0]  r_k;
  logic [LEN_W-1:0]  r_o;
  logic              r_req;
  logic              r_pend;
  logic [ADDR_W-1:0] r_addr;
  logic              r_done;
  logic              r_err;
  logic              r_clr;
  logic              r_outv;

  logic              w_fire;
  logic              w_accept;
  logic              w_pendAfter;
  logic              w_abort;
  logic              w_lastK;
  logic              w_lastOut;
  logic              w_cfgErr;
  logic [ADDR_W-1:0] w_inAddr;

  // w_fire is the reply to our own outstanding read. Gating it with r_pend
  // drops a stray rvalid, such as one that arrives after a reset.
  assign w_fire      = r_pend & mem_rvalid_i;
  assign w_accept    = r_req & mem_gnt_i;
  assign w_pendAfter = (r_pend & ~mem_rvalid_i) | w_accept;
  assign w_abort     = abort_i & (r_state != S_IDLE) & (r_state != S_DRAIN);
  assign w_lastK     = (r_k == r_kLen - LEN_W'(1));
  assign w_lastOut   = (r_o == r_inLen - r_kLen);
  assign w_cfgErr    = (r_kLen == '0) || (r_kLen > KMAX_LEN) || (r_kLen > r_inLen);
  assign w_inAddr    = r_inBase + (ADDR_W'(r_o) << 2);

  // The write and accumulate strobes follow rvalid in the same cycle. An
  // abort in that cycle discards the data.
  assign wgt_we_o    = w_fire & ~abort_i & (r_state == S_LOAD_W);
  assign mac_en_o    = w_fire & ~abort_i & (r_state == S_CONV);
  assign wgt_idx_o   = r_k[IDX_W-1:0];

  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign mem_req_o   = r_req;
  assign mem_addr_o  = r_addr;
  assign mac_clr_o   = r_clr;
  assign out_valid_o = r_outv;

  // Main sequencer. The request bookkeeping (r_req/r_pend) runs first.
  // State-specific code may then re-raise r_req for the next fetch, which it
  // only does after the previous read has returned.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_inBase  <= '0;
      r_wgtBase <= '0;
      r_inLen   <= '0;
      r_kLen    <= '0;
      r_k       <= '0;
      r_o       <= '0;
      r_req     <= 1'b0;
      r_pend    <= 1'b0;
      r_addr    <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_clr     <= 1'b0;
      r_outv    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_clr  <= 1'b0;
      if (w_accept) begin
        r_req  <= 1'b0;
        r_pend <= 1'b1;
      end
      if (w_fire) begin
        r_pend <= 1'b0;
      end

      if (w_abort) begin
        // An ungranted request is simply withdrawn. A granted one must be
        // drained first.
        r_req   <= 1'b0;
        r_outv  <= 1'b0;
        r_pend  <= w_pendAfter;
        r_state <= w_pendAfter ? S_DRAIN : S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start_i) begin
              r_inBase  <= in_base_i;
              r_wgtBase <= wgt_base_i;
              r_inLen   <= in_len_i;
              r_kLen    <= k_len_i;
              r_state   <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (w_cfgErr) begin
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_err   <= 1'b0;
              r_k     <= '0;
              r_o     <= '0;
              r_req   <= 1'b1;
              r_addr  <= r_wgtBase;
              r_state <= S_LOAD_W;
            end
          end
          S_LOAD_W: begin
            if (w_fire) begin
              if (w_lastK) begin
                r_k     <= '0;
                r_clr   <= 1'b1;
                r_state <= S_CONV;
              end else begin
                r_k    <= r_k + LEN_W'(1);
                r_req  <= 1'b1;
                r_addr <= r_addr + WORD_BYTES;
              end
            end
          end
          S_CONV: begin
            // The clear cycle opens each output. The first sample request
            // follows it, at in_base + 4*o.
            if (r_clr) begin
              r_req  <= 1'b1;
              r_addr <= w_inAddr;
            end else if (w_fire) begin
              if (w_lastK) begin
                r_outv  <= 1'b1;
                r_state <= S_OUT;
              end else begin
                r_k    <= r_k + LEN_W'(1);
                r_req  <= 1'b1;
                r_addr <= r_addr + WORD_BYTES;
              end
            end
          end
          S_OUT: begin
            if (out_ready_i) begin
              r_outv <= 1'b0;
              r_o    <= r_o + LEN_W'(1);
              r_k    <= '0;
              if (w_lastOut) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_clr   <= 1'b1;
                r_state <= S_CONV;
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          S_DRAIN: begin
            if (w_fire) begin
              r_state <= S_IDLE;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/conv1d_ctrl_fsm.md
# conv1d_ctrl_fsm

Sequencer for the conv1d accelerator. It sits between the control-register block and the conv1d datapath. It takes a start pulse and the job configuration (input base, weight base, input length, kernel length) from the control registers. It then fetches weights and input samples over a single-outstanding memory read port, drives the MAC datapath, hands each result to the output stage, and reports busy/done/error back to the registers.

## Interface
- ADDR_W, 32: byte address width of the memory port
- LEN_W, 16: width of length fields (samples)
- KMAX, 16: max supported kernel length (weight buffer depth)
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  one-cycle start pulse from control register
- abort_i  in  1  abandon current job
- in_base_i  in  ADDR_W  input vector base address (word aligned)
- wgt_base_i  in  ADDR_W  weight vector base address (word aligned)
- in_len_i  in  LEN_W  number of input samples N
- k_len_i  in  LEN_W  kernel length K
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle pulse on job end (normal or error)
- err_o  out  1  sticky config error, cleared on next accepted start
- mem_req_o  out  1  read request
- mem_addr_o  out  ADDR_W  read address
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read data valid (data goes straight to datapath)
- wgt_we_o  out  1  write returned word into weight buffer
- wgt_idx_o  out  $clog2(KMAX)  weight buffer index for write / MAC read
- mac_clr_o  out  1  clear accumulator
- mac_en_o  out  1  accumulate returned sample × weight[wgt_idx_o]
- out_valid_o  out  1  accumulator holds a finished output
- out_ready_i  in  1  output stage accepts result

## Operation
- States: IDLE, CHECK, LOAD_W, CONV, OUT, DONE.
- IDLE: start_i latches the config and goes to CHECK. start_i in any other state is ignored.
- CHECK, 1 cycle: error if K==0, K>KMAX, or K>N.
  - On error: set err_o and go to DONE.
  - Otherwise: clear err_o, reset k=0, o=0, and go to LOAD_W.
- Memory protocol: mem_req_o and mem_addr_o are held stable until mem_gnt_i. No new request is issued until mem_rvalid_i for the previous one. rvalid arrives ≥1 cycle after gnt.
- LOAD_W: for k=0..K-1, request wgt_base+4k.
  - On rvalid: wgt_we_o=1, wgt_idx_o=k, then k++.
  - After the K-th rvalid: k=0, go to CONV.
- CONV: mac_clr_o is pulsed in the first cycle of each output (k==0, before the first request).
  - For k=0..K-1, request in_base+4(o+k).
  - On rvalid: mac_en_o=1, wgt_idx_o=k, then k++.
  - After the K-th rvalid: go to OUT.
- OUT: out_valid_o=1 until out_ready_i.
  - On handshake: o++, k=0.
  - If o == N-K (last output): go to DONE; otherwise go to CONV.
- Output count is N-K+1 (valid convolution, no padding).
- DONE: done_o=1 for one cycle, then IDLE.
- busy_o=1 in every state except IDLE.
- Address arithmetic is modulo 2^ADDR_W (wraps silently). Counters are LEN_W bits; o+k never exceeds N-1 for legal configs.
- abort_i, in any non-IDLE state: go to IDLE next cycle. No done_o pulse; err_o is unchanged.
  - If a request is granted but rvalid is still pending, remain in a drain step until rvalid, discarding the data (no we/en), then go to IDLE.
  - An ungranted request is dropped immediately.

## Timing
- Reset values: state IDLE; busy_o, done_o, err_o, mem_req_o, wgt_we_o, mac_clr_o, mac_en_o, out_valid_o = 0; mem_addr_o, wgt_idx_o = 0.
- start_i at cycle t: CHECK at t+1; first mem_req_o at t+2.
- wgt_we_o and mac_en_o are combinational with mem_rvalid_i (same cycle).
- Next request is asserted the cycle after rvalid. With gnt in the request cycle and rvalid the next cycle, each fetch takes 2 cycles.
- Minimum job length: 2 + 2K + (N-K+1)·(1 + 2K + 1) + 1 cycles.
- out_valid_o rises the cycle after the K-th rvalid. out_ready_i already high gives a 1-cycle OUT.
- err_o is updated at the CHECK→next transition; done_o follows 1 cycle after an error.
- abort_i and out_ready_i in the same cycle: abort wins, o is not incremented.
- rst_i mid-job: all outputs return to reset values asynchronously; pending rvalid after reset is ignored.

## Test plan
- N=4, K=2, zero-latency memory (gnt same cycle, rvalid +1), out_ready=1 -> 2 weight reads at wgt_base, wgt_base+4; 3 outputs; input addresses in_base+{0,4},{4,8},{8,12}; done_o once; busy_o low after.
- K=0, K=KMAX+1, and N=3/K=4 -> no mem_req_o, err_o=1, done_o pulse 2 cycles after start; next legal start clears err_o.
- Random gnt delays 0–5 and rvalid delays 1–4 on N=8, K=3 -> address held stable until gnt, never 2 outstanding, exactly 3+6·3=21 reads, 6 outputs.
- out_ready_i low for 10 cycles on output 0 -> out_valid_o held, no further mem_req_o, o not advanced.
- abort_i after gnt, before rvalid, in CONV -> no mac_en_o on the returning data, IDLE after rvalid, no done_o; start_i during busy has no effect.
- rst_i asserted mid-LOAD_W -> all outputs 0 immediately; a fresh start then runs a normal job.
